timer_sequencer: RTL

Drives the two-digit BCD countdown timer (`two_digit_timer`) from the game controller side. The block validates and loads a BCD preset, then issues one-cycle decrement pulses at a fixed prescaled rate. It supports pause, resume and abort, and reports expiry when the timer raises `time_stop`. It sits between the game FSM and the timer and is the only source of the timer's `load`, `decrement` and hold controls.

---
 rtl/timer_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 39 +++
 rtl/timer_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state type, BCD check and default preset for the timer sequencer
package timer_pkg;

  localparam logic [7:0] TIMER_DEFAULT_BCD = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSED,
    ST_EXPIRED
  } seq_state_t;

  function automatic logic bcd_valid(input logic [7:0] value);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divide-by-TICKS_PER_SEC counter with clear and enable
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] count;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = (count == LAST) ? '0 : count + W'(1);
    end
  end

  // tick looks ahead: the count will sit at its terminal value after the
  // coming edge, so the owner can register a pulse aligned with that count.
  assign tick = (count_next == LAST);

  always_ff @(posedge clock) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - load/run/pause/abort sequencer driving the two-digit BCD countdown timer
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int         TICKS_PER_SEC = 50_000_000,
  parameter logic [7:0] DEFAULT_TIME  = TIMER_DEFAULT_BCD
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [7:0] preset_bcd,
  input  logic       time_stop,
  output logic       load,
  output logic [7:0] load_value,
  output logic       decrement,
  output logic       timer_hold,
  output logic       expired,
  output logic       preset_err,
  output logic       busy
);

  seq_state_t state;
  seq_state_t state_next;

  logic       tick;
  logic       presc_clr;
  logic       presc_en;
  logic       preset_ok;
  logic       accept;
  logic       load_d;
  logic [7:0] load_value_d;
  logic       decrement_d;
  logic       timer_hold_d;
  logic       expired_d;
  logic       preset_err_d;
  logic       busy_d;

  assign presc_clr = (state == ST_IDLE) || (state == ST_LOAD);
  assign presc_en  = (state == ST_RUN);

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clock(clock),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    preset_ok    = bcd_valid(preset_bcd) && (preset_bcd != 8'h00);
    accept       = 1'b0;
    load_value_d = load_value;

    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_EXPIRED: if (start) state_next = ST_LOAD;
        ST_LOAD:             state_next = ST_RUN;
        // Expiry wins over a simultaneous pause so the end of count is never lost.
        ST_RUN: begin
          if (time_stop)  state_next = ST_EXPIRED;
          else if (pause) state_next = ST_PAUSED;
        end
        ST_PAUSED:           if (!pause) state_next = ST_RUN;
        default:             state_next = ST_IDLE;
      endcase
    end

    accept = (state_next == ST_LOAD);
    if (accept) begin
      load_value_d = preset_ok ? preset_bcd : DEFAULT_TIME;
    end

    load_d       = accept;
    preset_err_d = accept && !preset_ok;
    decrement_d  = (state_next == ST_RUN) && tick;
    expired_d    = (state == ST_RUN) && (state_next == ST_EXPIRED);
    timer_hold_d = (state_next == ST_IDLE) || (state_next == ST_PAUSED) ||
                   (state_next == ST_EXPIRED);
    busy_d       = (state_next == ST_LOAD) || (state_next == ST_RUN) ||
                   (state_next == ST_PAUSED);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      load       <= 1'b0;
      load_value <= DEFAULT_TIME;
      decrement  <= 1'b0;
      timer_hold <= 1'b1;
      expired    <= 1'b0;
      preset_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load       <= load_d;
      load_value <= load_value_d;
      decrement  <= decrement_d;
      timer_hold <= timer_hold_d;
      expired    <= expired_d;
      preset_err <= preset_err_d;
      busy       <= busy_d;
    end
  end

endmodule
